// File: rtl/cyphertext_fetch_ctrl.sv
// Sequencer that walks the cyphertext/key ROM block by block and hands each
// registered block, plus the run's key, to the AES-128 decryption core.
module cyphertext_fetch_ctrl #(
  parameter int TEXT_WIDTH = 128,
  parameter int KEY_WIDTH  = 128,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_BLOCKS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  input  logic [TEXT_WIDTH-1:0] cyphertext_i,
  input  logic [KEY_WIDTH-1:0]  key_i,
  output logic [TEXT_WIDTH-1:0] text_o,
  output logic [KEY_WIDTH-1:0]  key_o,
  output logic [ADDR_WIDTH-1:0] blk_idx_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(NUM_BLOCKS - 1);

  state_t state, state_nxt;
  logic   handshake;
  logic   last_blk;

  assign handshake = valid_o & ready_i;
  assign last_blk  = (pc_o == LAST_PC);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = FETCH;
      FETCH:   state_nxt = ISSUE;
      ISSUE:   if (handshake) state_nxt = last_blk ? DONE : FETCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state != IDLE);
    done_o = (state == DONE);
  end

  // Block data is captured in FETCH and frozen through ISSUE until accepted;
  // the key is captured only on the first block so a run uses a single key.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_o      <= '0;
      text_o    <= '0;
      key_o     <= '0;
      blk_idx_o <= '0;
      valid_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: pc_o <= '0;
        FETCH: begin
          text_o    <= cyphertext_i;
          blk_idx_o <= pc_o;
          valid_o   <= 1'b1;
          if (pc_o == '0) key_o <= key_i;
        end
        ISSUE: begin
          if (handshake) begin
            valid_o <= 1'b0;
            if (!last_blk) pc_o <= pc_o + ADDR_WIDTH'(1);
          end
        end
        DONE: pc_o <= '0;
        default: pc_o <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cyphertext_fetch_ctrl.sv
// Directed bench for cyphertext_fetch_ctrl: a 16-block instance and a
// single-block instance, each fed by a combinational ROM model.
module tb_cyphertext_fetch_ctrl;

  localparam logic [127:0] KEY_AA = {16{8'hAA}};
  localparam logic [127:0] KEY_55 = {16{8'h55}};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, ready;
  logic [3:0]   pc, blk;
  logic [127:0] cyph, key_in, text, key_out;
  logic         valid, busy, done;

  logic         start2, ready2;
  logic [3:0]   pc2, blk2;
  logic [127:0] cyph2, text2, key_out2;
  logic         valid2, busy2, done2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [127:0] rom(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {16{b}};
  endfunction

  assign cyph  = rom(int'(pc));
  assign cyph2 = rom(int'(pc2));

  cyphertext_fetch_ctrl #(.TEXT_WIDTH(128), .KEY_WIDTH(128), .ADDR_WIDTH(4), .NUM_BLOCKS(16)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .pc_o(pc), .cyphertext_i(cyph),
    .key_i(key_in), .text_o(text), .key_o(key_out), .blk_idx_o(blk),
    .valid_o(valid), .ready_i(ready), .busy_o(busy), .done_o(done)
  );

  cyphertext_fetch_ctrl #(.TEXT_WIDTH(128), .KEY_WIDTH(128), .ADDR_WIDTH(4), .NUM_BLOCKS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start2), .pc_o(pc2), .cyphertext_i(cyph2),
    .key_i(key_in), .text_o(text2), .key_o(key_out2), .blk_idx_o(blk2),
    .valid_o(valid2), .ready_i(ready2), .busy_o(busy2), .done_o(done2)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hs_cnt, last_hs, cyc, done_cnt;

    rst_n = 1'b0; start = 1'b0; ready = 1'b1; key_in = KEY_AA;
    start2 = 1'b0; ready2 = 1'b1;

    // Reset state
    step(); step();
    chk("rst_valid", valid, 0);  chk("rst_busy", busy, 0);  chk("rst_done", done, 0);
    chk("rst_pc", pc, 0);        chk("rst_text", text, 0);  chk("rst_key", key_out, 0);
    chk("rst_blk", blk, 0);      chk("rst1_valid", valid2, 0); chk("rst1_busy", busy2, 0);
    rst_n = 1'b1;
    step();
    chk("idle_busy", busy, 0);

    // Full 16-block run, ready held high, key changes after first block
    start = 1'b1;
    step();
    start = 1'b0;
    chk("a_busy_t1", busy, 1);
    chk("a_valid_t1", valid, 0);
    step();
    chk("a_valid_t2", valid, 1);
    hs_cnt = 0; done_cnt = 0; cyc = 0; last_hs = -10;
    while (cyc < 100 && busy) begin
      if (valid && ready) begin
        chk("a_text", text, rom(hs_cnt));
        chk("a_blk", blk, 128'(hs_cnt));
        chk("a_pc", pc, 128'(hs_cnt));
        chk("a_key", key_out, KEY_AA);
        if (hs_cnt > 0) chk("a_gap", 128'(cyc - last_hs), 2);
        last_hs = cyc;
        hs_cnt++;
        key_in = KEY_55;
      end
      if (done) begin
        done_cnt++;
        chk("a_done_lat", 128'(cyc - last_hs), 1);
      end
      step();
      cyc++;
    end
    chk("a_hs_cnt", 128'(hs_cnt), 16);
    chk("a_done_cnt", 128'(done_cnt), 1);
    chk("a_idle_lat", 128'(cyc - last_hs), 2);
    chk("a_end_busy", busy, 0);
    chk("a_end_pc", pc, 0);
    chk("a_end_key", key_out, KEY_AA);

    // Stall at block 3, then abort with reset at block 7
    key_in = KEY_AA;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (cyc < 40 && !(valid && blk == 4'd3)) begin step(); cyc++; end
    chk("b_reach3", blk, 3);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("b_stall_valid", valid, 1);
      chk("b_stall_text", text, rom(3));
      chk("b_stall_pc", pc, 3);
      chk("b_stall_blk", blk, 3);
    end
    ready = 1'b1;
    step();
    chk("b_fetch4_valid", valid, 0);
    chk("b_fetch4_pc", pc, 4);
    step();
    chk("b_issue4_valid", valid, 1);
    chk("b_issue4_text", text, rom(4));
    chk("b_issue4_blk", blk, 4);
    cyc = 0;
    while (cyc < 40 && !(valid && blk == 4'd7)) begin step(); cyc++; end
    chk("b_reach7", blk, 7);
    rst_n = 1'b0;
    step();
    chk("b_rst_valid", valid, 0);
    chk("b_rst_pc", pc, 0);
    chk("b_rst_busy", busy, 0);
    chk("b_rst_done", done, 0);
    chk("b_rst_text", text, 0);
    rst_n = 1'b1;
    step();
    chk("b_post_done", done, 0);
    chk("b_post_busy", busy, 0);

    // Single-block instance with start held high: run, done, relaunch
    start2 = 1'b1;
    step();
    chk("c_fetch_busy", busy2, 1);   chk("c_fetch_valid", valid2, 0); chk("c_pc0", pc2, 0);
    step();
    chk("c_issue_valid", valid2, 1); chk("c_issue_text", text2, rom(0));
    chk("c_issue_blk", blk2, 0);     chk("c_pc1", pc2, 0);
    step();
    chk("c_done", done2, 1);         chk("c_done_valid", valid2, 0); chk("c_pc2", pc2, 0);
    step();
    chk("c_idle_busy", busy2, 0);    chk("c_idle_done", done2, 0);   chk("c_pc3", pc2, 0);
    step();
    chk("c_relaunch_busy", busy2, 1); chk("c_relaunch_valid", valid2, 0);
    step();
    chk("c_relaunch_issue", valid2, 1); chk("c_pc4", pc2, 0);
    start2 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
